// File: rtl/circuito_decodificador_sequencial.sv
// Decodes a 3-bit code into one of seven one-hot lines, held for HOLD cycles, then a DONE pulse.
// Latency: one cycle from the sampling edge of V to the one-hot line.
// Backpressure: none; V is only sampled in IDLE and is ignored while BUSY.
module circuito_decodificador_sequencial #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       F1,
  input  logic       F2,
  input  logic       F3,
  input  logic       V,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] CNT
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HOLD = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  logic [1:0] state_q;
  logic [3:0] hold_cnt_q;
  logic [6:0] onehot_q;
  logic       err_q;
  logic [7:0] cnt_q;
  logic [2:0] code;
  logic       accept;
  logic       reject;

  assign code   = {F1, F2, F3};
  assign accept = (state_q == ST_IDLE) && V && (code != 3'b000);
  assign reject = (state_q == ST_IDLE) && V && (code == 3'b000);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= 4'd0;
      onehot_q   <= 7'd0;
      err_q      <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      err_q <= reject;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= HOLD_M1;
            onehot_q   <= 7'b0000001 << (code - 3'd1);
            cnt_q      <= cnt_q + 8'd1;
          end
        end
        ST_HOLD: begin
          // Counter value 0 marks the last held cycle.
          if (hold_cnt_q == 4'd0) begin
            state_q  <= ST_DONE;
            onehot_q <= 7'd0;
          end else begin
            hold_cnt_q <= hold_cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          hold_cnt_q <= 4'd0;
          onehot_q   <= 7'd0;
        end
      endcase
    end
  end

  assign {G, F, E, D, C, B, A} = onehot_q;
  assign BUSY = (state_q == ST_HOLD) || (state_q == ST_DONE);
  assign DONE = (state_q == ST_DONE);
  assign ERR  = err_q;
  assign CNT  = cnt_q;

endmodule

// File: tb/tb_circuito_decodificador_sequencial.sv
// Randomized and directed stimulus against a schedule-based reference model of the decoder.
module tb_circuito_decodificador_sequencial;

  localparam int HOLD = 4;

  logic       clk;
  logic       reset;
  logic       F1, F2, F3, V;
  logic       A, B, C, D, E, F, G;
  logic       BUSY, DONE, ERR;
  logic [7:0] CNT;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: when the last code was accepted, which code, and when the next sample may occur.
  int         k         = 0;
  int         acc_edge  = -100;
  int         err_edge  = -100;
  int         next_free = 0;
  int         m_cnt     = 0;
  logic [2:0] acc_code  = 3'd1;

  circuito_decodificador_sequencial #(.HOLD(HOLD)) dut (
    .clk(clk), .reset(reset),
    .F1(F1), .F2(F2), .F3(F3), .V(V),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CNT(CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, got, exp);
  endtask

  task automatic check_outputs();
    int         d;
    logic [6:0] exp_oh;
    logic [6:0] got_oh;
    d      = k - acc_edge;
    exp_oh = 7'd0;
    if (d >= 0 && d < HOLD) exp_oh = 7'b0000001 << (int'(acc_code) - 1);
    got_oh = {G, F, E, D, C, B, A};
    chk("onehot", 32'(got_oh), 32'(exp_oh));
    chk("busy",   32'(BUSY), 32'((d >= 0 && d <= HOLD) ? 1 : 0));
    chk("done",   32'(DONE), 32'((d == HOLD) ? 1 : 0));
    chk("err",    32'(ERR),  32'((err_edge == k) ? 1 : 0));
    chk("cnt",    32'(CNT),  32'(m_cnt));
    chk("at_most_one_line", 32'($countones(got_oh) <= 1), 32'd1);
    chk("done_err_exclusive", 32'(DONE && ERR), 32'd0);
  endtask

  task automatic step(input logic r, input logic v, input logic [2:0] c);
    reset = r;
    V     = v;
    {F1, F2, F3} = c;
    @(posedge clk);
    #1;
    k++;
    if (r) begin
      m_cnt     = 0;
      acc_edge  = -100;
      err_edge  = -100;
      next_free = k + 1;
    end else if (v && k >= next_free) begin
      if (c != 3'b000) begin
        acc_edge  = k;
        acc_code  = c;
        m_cnt     = (m_cnt + 1) % 256;
        next_free = k + HOLD + 2;
      end else begin
        err_edge = k;
      end
    end
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'($urandom_range(0, 7)));
  endtask

  initial begin
    reset = 1'b1;
    V     = 1'b0;
    {F1, F2, F3} = 3'b000;

    // Reset state, then a single code 011.
    step(1'b1, 1'b1, 3'b011);
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b011);
    chk("c_first_cycle", 32'(C), 32'd1);
    idle(HOLD + 2);
    chk("cnt_after_011", 32'(CNT), 32'd1);

    // Sweep every non-zero code.
    for (int c = 1; c < 8; c++) begin
      step(1'b0, 1'b1, 3'(c));
      idle(HOLD + 1 + $urandom_range(0, 2));
    end
    chk("cnt_after_sweep", 32'(CNT), 32'd8);

    // Rejected code 000 in IDLE.
    step(1'b0, 1'b1, 3'b000);
    chk("err_pulse", 32'(ERR), 32'd1);
    idle(2);

    // Code 101 accepted, then 010 offered while holding.
    step(1'b0, 1'b1, 3'b101);
    for (int i = 0; i < HOLD; i++) step(1'b0, 1'b1, 3'b010);
    step(1'b0, 1'b0, 3'b000);
    idle(2);
    chk("cnt_ignore_v_busy", 32'(CNT), 32'd9);

    // Reset during the second held cycle of code 111.
    step(1'b0, 1'b1, 3'b111);
    step(1'b0, 1'b0, 3'b000);
    step(1'b1, 1'b1, 3'b111);
    chk("g_cleared_by_reset", 32'(G), 32'd0);
    idle(HOLD + 2);

    // V held high with code 001 for 256 presentations: CNT wraps, spacing HOLD+2.
    for (int i = 0; i < 256 * (HOLD + 2); i++) step(1'b0, 1'b1, 3'b001);
    idle(HOLD + 2);
    chk("cnt_wrap", 32'(CNT), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
